// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-port byte-addressed data memory between
// a CPU load/store port (0) and a DMA/debug port (1); IDLE -> ACCESS -> RESP.

module dmem_arbiter_port #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  sel_i,
  input  logic                  err_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic                  ack_o,
  output logic                  err_o,
  output logic [DATA_WIDTH-1:0] rdata_o
);
  assign ack_o   = sel_i;
  assign err_o   = sel_i & err_i;
  assign rdata_o = sel_i ? rdata_i : '0;
endmodule

module dmem_arbiter #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int ADDR_REAL_WIDTH = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  r0_req,
  input  logic [2:0]            r0_mode,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  output logic                  r0_ack,
  output logic                  r0_err,
  output logic [DATA_WIDTH-1:0] r0_rdata,
  input  logic                  r1_req,
  input  logic [2:0]            r1_mode,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  output logic                  r1_ack,
  output logic                  r1_err,
  output logic [DATA_WIDTH-1:0] r1_rdata,
  output logic [2:0]            mem_mode,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wd,
  input  logic [DATA_WIDTH-1:0] mem_rd,
  output logic                  busy
);
  localparam logic [2:0] MODE_LW = 3'b010;
  localparam int         EW      = ADDR_REAL_WIDTH + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_e;

  typedef struct packed {
    logic [2:0]            mode;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  function automatic logic is_store(input logic [2:0] m);
    return m[2] & (m[1] | m[0]);
  endfunction

  function automatic logic [2:0] acc_size(input logic [2:0] m);
    case (m)
      3'b000, 3'b011, 3'b101: return 3'd1;
      3'b001, 3'b100, 3'b110: return 3'd2;
      default:                return 3'd4;
    endcase
  endfunction

  state_e                state_q, state_d;
  req_t                  cur_q, cur_d;
  logic                  last_q, last_d;
  logic                  port_q, port_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [1:0]            req;
  req_t [1:0]            rq;
  logic                  win;
  req_t                  win_rq;
  logic [EW-1:0]         win_end;
  logic                  range_err;

  assign req   = {r1_req, r0_req};
  assign rq[0] = {r0_mode, r0_addr, r0_wdata};
  assign rq[1] = {r1_mode, r1_addr, r1_wdata};

  // On a tie the port not granted last wins; otherwise the lone requester.
  assign win    = (&req) ? ~last_q : req[1];
  assign win_rq = rq[win];

  // Carry out of the low address bits means the access runs off the top.
  assign win_end   = {1'b0, win_rq.addr[ADDR_REAL_WIDTH-1:0]}
                   + EW'(acc_size(win_rq.mode) - 3'd1);
  assign range_err = (|win_rq.addr[ADDR_WIDTH-1:ADDR_REAL_WIDTH]) | win_end[EW-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cur_q   <= '0;
      last_q  <= 1'b1;
      port_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      last_q  <= last_d;
      port_q  <= port_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    last_d  = last_q;
    port_d  = port_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          cur_d   = win_rq;
          port_d  = win;
          last_d  = win;
          err_d   = range_err;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        rdata_d = (!err_q && !is_store(cur_q.mode)) ? mem_rd : '0;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory is only driven during ACCESS; a range error downgrades to a read.
  always_comb begin
    mem_mode = MODE_LW;
    mem_addr = '0;
    mem_wd   = '0;
    if (state_q == ACCESS) begin
      mem_addr = cur_q.addr;
      mem_wd   = cur_q.wdata;
      if (!err_q) mem_mode = cur_q.mode;
    end
  end

  assign busy = (state_q != IDLE);

  logic [1:0]                 ack_v, err_v;
  logic [1:0][DATA_WIDTH-1:0] rdata_v;

  for (genvar g = 0; g < 2; g++) begin : g_port
    localparam logic ID = 1'(g);
    dmem_arbiter_port #(.DATA_WIDTH(DATA_WIDTH)) u_port (
      .sel_i   ((state_q == RESP) && (port_q == ID)),
      .err_i   (err_q),
      .rdata_i (rdata_q),
      .ack_o   (ack_v[g]),
      .err_o   (err_v[g]),
      .rdata_o (rdata_v[g])
    );
  end

  assign r0_ack   = ack_v[0];
  assign r0_err   = err_v[0];
  assign r0_rdata = rdata_v[0];
  assign r1_ack   = ack_v[1];
  assign r1_err   = err_v[1];
  assign r1_rdata = rdata_v[1];
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: attached byte memory, table vectors, hand sequences
// for arbitration/reset corners, and random traffic against a transaction model.

module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        r0_req, r1_req;
  logic [2:0]  r0_mode, r1_mode;
  logic [31:0] r0_addr, r1_addr, r0_wdata, r1_wdata;
  logic        r0_ack, r1_ack, r0_err, r1_err;
  logic [31:0] r0_rdata, r1_rdata;
  logic [2:0]  mem_mode;
  logic [31:0] mem_addr, mem_wd, mem_rd;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ADDR_REAL_WIDTH(20)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_mode(r0_mode), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ack(r0_ack), .r0_err(r0_err), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_mode(r1_mode), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ack(r1_ack), .r1_err(r1_err), .r1_rdata(r1_rdata),
    .mem_mode(mem_mode), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd),
    .busy(busy)
  );

  function automatic int msize(input logic [2:0] m);
    if (m == 3'd0 || m == 3'd3 || m == 3'd5) return 1;
    if (m == 3'd1 || m == 3'd4 || m == 3'd6) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ext(input logic [2:0] m, input logic [31:0] v);
    if (m == 3'd0) return {{24{v[7]}}, v[7:0]};
    if (m == 3'd1) return {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  // Physical memory seen by the DUT: combinational read, write on posedge.
  logic [7:0] dmem [0:1048575];
  always_comb begin
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 4; i++)
      if (i < msize(mem_mode)) v[8*i +: 8] = dmem[20'(mem_addr + 32'(i))];
    mem_rd = ext(mem_mode, v);
  end
  always @(posedge clk) begin
    if (mem_mode[2] & (mem_mode[1] | mem_mode[0]))
      for (int i = 0; i < 4; i++)
        if (i < msize(mem_mode)) dmem[20'(mem_addr + 32'(i))] <= mem_wd[8*i +: 8];
  end

  // Transaction-level reference: whole accesses applied to a plain byte array.
  logic [7:0] ref_mem [0:1048575];
  function automatic void ref_access(input logic [2:0] m, input logic [31:0] a,
                                     input logic [31:0] wd, output logic [31:0] rd,
                                     output logic er);
    longint last;
    logic [31:0] v;
    last = longint'({32'b0, a}) + longint'(msize(m)) - 1;
    er = (last > 64'hFFFFF);
    rd = '0;
    v  = '0;
    if (er) return;
    for (int i = 0; i < msize(m); i++) begin
      if (m >= 3'd5) ref_mem[int'(a) + i] = wd[8*i +: 8];
      else           v[8*i +: 8] = ref_mem[int'(a) + i];
    end
    if (m < 3'd5) rd = ext(m, v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Issue one request from IDLE, wait for ack, return in the next IDLE cycle.
  task automatic txn(input int p, input logic [2:0] m, input logic [31:0] a,
                     input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int lat;
    bit got;
    got = 0; lat = 0; rd = '0; er = 1'b0;
    if (p == 0) begin r0_mode = m; r0_addr = a; r0_wdata = wd; r0_req = 1'b1; end
    else        begin r1_mode = m; r1_addr = a; r1_wdata = wd; r1_req = 1'b1; end
    while (!got && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if ((p == 0) ? r0_ack : r1_ack) begin
        got = 1;
        rd  = (p == 0) ? r0_rdata : r1_rdata;
        er  = (p == 0) ? r0_err : r1_err;
        chk("other_port_quiet", (p == 0) ? (32'(r1_ack) | 32'(r1_err) | r1_rdata)
                                         : (32'(r0_ack) | 32'(r0_err) | r0_rdata), 32'h0);
      end
    end
    r0_req = 1'b0; r1_req = 1'b0;
    chk("latency", 32'(lat), 32'd2);
    @(posedge clk); #1;
  endtask

  typedef struct {
    int          port;
    logic [2:0]  mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t tbl [16];

  initial begin
    logic [31:0] rd, rr;
    logic        er, re;
    int          order [3];
    int          cyc   [3];
    int          nack, n0;

    tbl[0]  = '{0, 3'b111, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    tbl[1]  = '{0, 3'b010, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 1'b0};
    tbl[2]  = '{1, 3'b101, 32'h0000_0200, 32'h0000_0080, 32'h0000_0000, 1'b0};
    tbl[3]  = '{1, 3'b000, 32'h0000_0200, 32'h0,         32'hFFFF_FF80, 1'b0};
    tbl[4]  = '{1, 3'b011, 32'h0000_0200, 32'h0,         32'h0000_0080, 1'b0};
    tbl[5]  = '{1, 3'b101, 32'h0000_01FF, 32'h0000_0000, 32'h0000_0000, 1'b0};
    tbl[6]  = '{1, 3'b001, 32'h0000_01FF, 32'h0,         32'hFFFF_8000, 1'b0};
    tbl[7]  = '{0, 3'b010, 32'h000F_FFFD, 32'h0,         32'h0000_0000, 1'b1};
    tbl[8]  = '{0, 3'b111, 32'h0010_0000, 32'hCAFE_F00D, 32'h0000_0000, 1'b1};
    tbl[9]  = '{0, 3'b010, 32'h0000_0000, 32'h0,         32'hA6A7_A4A5, 1'b0};
    tbl[10] = '{0, 3'b100, 32'h000F_FFFE, 32'h0,         32'h0000_5A5B, 1'b0};
    tbl[11] = '{0, 3'b001, 32'h000F_FFFF, 32'h0,         32'h0000_0000, 1'b1};
    tbl[12] = '{1, 3'b010, 32'h000F_FFFC, 32'h0,         32'h5A5B_5859, 1'b0};
    tbl[13] = '{1, 3'b000, 32'h000F_FFFF, 32'h0,         32'h0000_005A, 1'b0};
    tbl[14] = '{0, 3'b110, 32'h0000_0202, 32'hFFFF_1234, 32'h0000_0000, 1'b0};
    tbl[15] = '{0, 3'b010, 32'h8000_0000, 32'h0,         32'h0000_0000, 1'b1};

    for (int i = 0; i < 1048576; i++) begin
      dmem[i]    = 8'(i) ^ 8'hA5;
      ref_mem[i] = 8'(i) ^ 8'hA5;
    end

    rst = 1'b1;
    r0_req = 1'b0; r0_mode = 3'b0; r0_addr = '0; r0_wdata = '0;
    r1_req = 1'b0; r1_mode = 3'b0; r1_addr = '0; r1_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_mem_mode", 32'(mem_mode), 32'h2);
    chk("rst_mem_addr_wd", mem_addr | mem_wd, 32'h0);
    chk("rst_acks", 32'(r0_ack) | 32'(r1_ack) | 32'(r0_err) | 32'(r1_err) | r0_rdata | r1_rdata, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Tie out of reset: port 0, then port 1 wins the re-tie, then port 0 alone.
    r0_mode = 3'b010; r0_addr = 32'h0; r0_req = 1'b1;
    r1_mode = 3'b010; r1_addr = 32'h4; r1_req = 1'b1;
    nack = 0; n0 = 0;
    for (int k = 0; k < 3; k++) begin order[k] = -1; cyc[k] = -1; end
    for (int c = 1; c <= 30 && nack < 3; c++) begin
      @(posedge clk); #1;
      if (r0_ack && r1_ack) chk("tie_double_ack", 32'h1, 32'h0);
      else if (r0_ack) begin
        order[nack] = 0; cyc[nack] = c; nack++; n0++;
        chk("tie_p0_rdata", r0_rdata, 32'hA6A7_A4A5);
        if (n0 == 2) r0_req = 1'b0;
      end else if (r1_ack) begin
        order[nack] = 1; cyc[nack] = c; nack++;
        chk("tie_p1_rdata", r1_rdata, 32'hA2A3_A0A1);
        r1_req = 1'b0;
      end
    end
    r0_req = 1'b0; r1_req = 1'b0;
    chk("tie_ack_count", 32'(nack), 32'd3);
    chk("tie_order0", 32'(order[0]), 32'd0);
    chk("tie_order1", 32'(order[1]), 32'd1);
    chk("tie_order2", 32'(order[2]), 32'd0);
    chk("tie_cyc0", 32'(cyc[0]), 32'd2);
    chk("tie_cyc1", 32'(cyc[1]), 32'd5);
    chk("tie_cyc2", 32'(cyc[2]), 32'd8);
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) begin
      ref_access(tbl[i].mode, tbl[i].addr, tbl[i].wdata, rr, re);
      txn(tbl[i].port, tbl[i].mode, tbl[i].addr, tbl[i].wdata, rd, er);
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_err", i), 32'(er), 32'(tbl[i].exp_err));
      chk($sformatf("tbl%0d_model", i), rd, rr);
    end
    txn(1, 3'b010, 32'h200, 32'h0, rd, er);
    chk("sh_merge_rdata", rd, 32'h1234_A480);

    // Reset asserted during a store's ACCESS cycle must abort it.
    r0_mode = 3'b111; r0_addr = 32'h300; r0_wdata = 32'h1234_5678; r0_req = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", 32'(busy), 32'h1);
    chk("abort_access_mode", 32'(mem_mode), 32'h7);
    #2 rst = 1'b1;
    #1;
    chk("abort_mode_now", 32'(mem_mode), 32'h2);
    chk("abort_busy_now", 32'(busy), 32'h0);
    r0_req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("abort_no_ack", 32'(r0_ack) | 32'(r1_ack), 32'h0);
    end
    txn(0, 3'b010, 32'h300, 32'h0, rd, er);
    chk("abort_mem_kept", rd, 32'hA6A7_A4A5);

    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("idle_quiet", 32'(busy) | 32'(r0_ack) | 32'(r1_ack), 32'h0);
      chk("idle_mode", 32'(mem_mode), 32'h2);
    end

    for (int n = 0; n < 200; n++) begin
      int          p, sel;
      logic [2:0]  m;
      logic [31:0] a, wd;
      p   = int'($urandom_range(0, 1));
      m   = 3'($urandom_range(0, 7));
      wd  = $urandom;
      sel = int'($urandom_range(0, 9));
      if (sel < 6)       a = 32'h400 + $urandom_range(0, 63);
      else if (sel < 8)  a = 32'hF_FFF8 + $urandom_range(0, 7);
      else if (sel == 8) a = $urandom;
      else               a = 32'h10_0000 + $urandom_range(0, 3);
      ref_access(m, a, wd, rr, re);
      txn(p, m, a, wd, rd, er);
      chk($sformatf("rnd%0d_rdata", n), rd, rr);
      chk($sformatf("rnd%0d_err", n), 32'(er), 32'(re));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
